// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared UART transmit types, timeout and message characters
package uart_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_LAUNCH  = 2'd1,
        ST_WAIT_HI = 2'd2,
        ST_WAIT_LO = 2'd3
    } tx_state_e;

    // Cycles allowed in WAIT_HI before the launched byte is assumed sent.
    localparam int BUSY_TIMEOUT = 4;

    localparam logic [7:0] CH_H  = 8'h48;
    localparam logic [7:0] CH_E  = 8'h45;
    localparam logic [7:0] CH_L  = 8'h4C;
    localparam logic [7:0] CH_O  = 8'h4F;
    localparam logic [7:0] CH_LF = 8'h0A;

endpackage

// File: rtl/fifo_mem.sv
// rtl/fifo_mem.sv - DEPTH x DATA_W dual-port storage, registered write, combinational read
module fifo_mem #(
    parameter int DEPTH  = 16,
    parameter int DATA_W = 8
) (
    input  logic                     clk,
    input  logic                     we,
    input  logic [$clog2(DEPTH)-1:0] waddr,
    input  logic [DATA_W-1:0]        wdata,
    input  logic [$clog2(DEPTH)-1:0] raddr,
    output logic [DATA_W-1:0]        rdata
);

    logic [DATA_W-1:0] mem [DEPTH];

    // Write port; contents are don't-care until written, so no reset.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/uart_tx_fifo.sv
// rtl/uart_tx_fifo.sv - byte FIFO that paces launches into a UART transmitter
module uart_tx_fifo
    import uart_pkg::*;
#(
    parameter int DEPTH  = 16,
    parameter int DATA_W = 8
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [DATA_W-1:0]        in_data,
    input  logic                     in_valid,
    output logic                     in_ready,
    output logic [DATA_W-1:0]        out_data,
    output logic                     out_valid,
    input  logic                     tx_busy,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     overflow,
    input  logic                     ovf_clr
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam int TW = $clog2(BUSY_TIMEOUT);

    tx_state_e         state, state_nxt;
    logic [AW-1:0]     wr_ptr, rd_ptr;
    logic [TW-1:0]     wait_cnt;
    logic [DATA_W-1:0] rd_data;
    logic              push, launch;

    assign in_ready  = (count < CW'(DEPTH));
    assign push      = in_valid && in_ready;
    assign launch    = (state == ST_IDLE) && (count != '0) && !tx_busy;
    assign out_valid = (state == ST_LAUNCH);

    fifo_mem #(
        .DEPTH  (DEPTH),
        .DATA_W (DATA_W)
    ) u_mem (
        .clk   (clk),
        .we    (push),
        .waddr (wr_ptr),
        .wdata (in_data),
        .raddr (rd_ptr),
        .rdata (rd_data)
    );

    // Pointers and occupancy; pointers wrap naturally since DEPTH is a power of two.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (launch) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({push, launch})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    // Head byte is captured on the launch edge and held until the next launch.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_data <= '0;
        end else if (launch) begin
            out_data <= rd_data;
        end
    end

    // Sticky overflow; a new drop on the same edge as a clear keeps it set.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            overflow <= 1'b0;
        end else if (in_valid && !in_ready) begin
            overflow <= 1'b1;
        end else if (ovf_clr) begin
            overflow <= 1'b0;
        end
    end

    // Drain state register plus a cycle counter that only runs while in WAIT_HI.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= ST_IDLE;
            wait_cnt <= '0;
        end else begin
            state    <= state_nxt;
            wait_cnt <= (state == ST_WAIT_HI) ? wait_cnt + TW'(1) : '0;
        end
    end

    // Next-state: launch, wait for busy to rise (bounded), then wait for it to fall.
    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: begin
                if (launch) begin
                    state_nxt = ST_LAUNCH;
                end
            end
            ST_LAUNCH: begin
                state_nxt = ST_WAIT_HI;
            end
            ST_WAIT_HI: begin
                if (tx_busy) begin
                    state_nxt = ST_WAIT_LO;
                end else if (wait_cnt == TW'(BUSY_TIMEOUT - 1)) begin
                    state_nxt = ST_IDLE;
                end
            end
            ST_WAIT_LO: begin
                if (!tx_busy) begin
                    state_nxt = ST_IDLE;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// tb/tb_uart_tx_fifo.sv - self-checking bench for uart_tx_fifo
module tb_uart_tx_fifo;
    import uart_pkg::*;

    localparam int DEPTH = 16;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [7:0] in_data;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] out_data;
    logic       out_valid;
    logic       tx_busy = 1'b0;
    logic [4:0] count;
    logic       overflow;
    logic       ovf_clr;

    uart_tx_fifo #(.DEPTH(DEPTH), .DATA_W(8)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .out_data  (out_data),
        .out_valid (out_valid),
        .tx_busy   (tx_busy),
        .count     (count),
        .overflow  (overflow),
        .ovf_clr   (ovf_clr)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;
    int cyc      = 0;
    bit cmp_en   = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at cycle %0d", name, act, exp, cyc);
    endtask

    always @(posedge clk) cyc++;

    // Transmitter model: busy rises busy_delay cycles after a strobe, lasts busy_len.
    bit tx_hold  = 1'b0;
    bit tx_never = 1'b0;
    int busy_delay = 2;
    int busy_len   = 20;
    initial begin
        int t;
        t = 1000;
        forever begin
            @(negedge clk);
            if (rst_n !== 1'b1) t = 1000;
            else if (out_valid === 1'b1) t = 0;
            else if (t < 1000) t++;
            tx_busy = tx_hold || (!tx_never && t >= busy_delay && t < busy_delay + busy_len);
        end
    end

    // Reference model: queue of accepted bytes plus one outstanding transmission record.
    logic [7:0] m_q[$];
    logic [7:0] m_out      = 8'h00;
    bit         m_ovf      = 1'b0;
    bit         m_inflight = 1'b0;
    bit         m_strobe   = 1'b0;
    bit         m_saw_busy = 1'b0;
    int         m_age      = 0;
    always @(posedge clk or negedge rst_n) begin
        int sz;
        if (!rst_n) begin
            m_q.delete();
            m_out = 8'h00; m_ovf = 0; m_inflight = 0; m_strobe = 0; m_saw_busy = 0; m_age = 0;
        end else begin
            sz = m_q.size();
            if (!m_inflight) begin
                if (sz > 0 && !tx_busy) begin
                    m_out = m_q.pop_front();
                    m_inflight = 1; m_strobe = 1; m_saw_busy = 0; m_age = 0;
                end
            end else if (m_strobe) begin
                m_strobe = 0;
            end else if (!m_saw_busy) begin
                if (tx_busy) m_saw_busy = 1;
                else begin
                    m_age++;
                    if (m_age == BUSY_TIMEOUT) m_inflight = 0;
                end
            end else if (!tx_busy) begin
                m_inflight = 0;
            end
            if (in_valid && sz < DEPTH) m_q.push_back(in_data);
            if (in_valid && sz >= DEPTH) m_ovf = 1;
            else if (ovf_clr) m_ovf = 0;
        end
    end

    // Per-cycle comparison against the model, and a log of launched bytes.
    logic [7:0] out_log[$];
    int         out_cyc[$];
    always @(negedge clk) begin
        if (cmp_en) begin
            check("count", 32'(count), 32'(m_q.size()));
            check("in_ready", 32'(in_ready), 32'(m_q.size() < DEPTH));
            check("out_valid", 32'(out_valid), 32'(m_strobe));
            check("out_data", 32'(out_data), 32'(m_out));
            check("overflow", 32'(overflow), 32'(m_ovf));
            if (out_valid === 1'b1) begin
                out_log.push_back(out_data);
                out_cyc.push_back(cyc);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_byte(input logic [7:0] b);
        in_valid = 1'b1; in_data = b;
        tick();
        in_valid = 1'b0;
    endtask

    task automatic push_hs(input logic [7:0] b);
        bit acc;
        in_data = b;
        in_valid = 1'b1;
        for (int k = 0; k < 500; k++) begin
            acc = in_ready;
            tick();
            if (acc) break;
        end
        in_valid = 1'b0;
    endtask

    task automatic wait_drain(input string name, input int budget);
        for (int k = 0; k < budget && (m_q.size() != 0 || m_inflight); k++) tick();
        check(name, 32'(m_q.size() == 0 && !m_inflight), 32'd1);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    logic [7:0] exp_hello [6];
    logic [7:0] hello [6];
    int n0;

    initial begin
        exp_hello = '{8'h48, 8'h45, 8'h4C, 8'h4C, 8'h4F, 8'h0A};
        hello     = '{CH_H, CH_E, CH_L, CH_L, CH_O, CH_LF};
        rst_n = 1'b0; in_valid = 1'b0; in_data = 8'h00; ovf_clr = 1'b0;
        tick(); tick();
        check("rst_count", 32'(count), 32'd0);
        check("rst_in_ready", 32'(in_ready), 32'd1);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_out_data", 32'(out_data), 32'h00);
        check("rst_overflow", 32'(overflow), 32'd0);
        cmp_en = 1'b1;
        rst_n = 1'b1;
        tick();

        // Single byte with a well-behaved transmitter
        n0 = out_log.size();
        push_byte(CH_H);
        wait_drain("drain_single", 500);
        check("single_pulses", 32'(out_log.size() - n0), 32'd1);
        if (out_log.size() > n0) check("single_data", 32'(out_log[n0]), 32'h48);
        check("single_count", 32'(count), 32'd0);

        // HELLO\n back to back
        n0 = out_log.size();
        for (int i = 0; i < 6; i++) begin
            in_valid = 1'b1; in_data = hello[i];
            tick();
        end
        in_valid = 1'b0;
        wait_drain("drain_hello", 1000);
        check("hello_pulses", 32'(out_log.size() - n0), 32'd6);
        for (int i = 0; i < 6 && n0 + i < out_log.size(); i++)
            check("hello_data", 32'(out_log[n0 + i]), 32'(exp_hello[i]));

        // Fill to full with the transmitter held busy, then overflow
        tx_hold = 1'b1;
        tick(); tick();
        n0 = out_log.size();
        for (int i = 0; i < 17; i++) begin
            in_valid = 1'b1; in_data = 8'(i);
            tick();
            if (i == 15) check("full_in_ready", 32'(in_ready), 32'd0);
        end
        in_valid = 1'b0;
        check("full_count", 32'(count), 32'd16);
        check("full_overflow", 32'(overflow), 32'd1);
        ovf_clr = 1'b1; tick(); ovf_clr = 1'b0;
        check("ovf_cleared", 32'(overflow), 32'd0);
        in_valid = 1'b1; ovf_clr = 1'b1; tick(); in_valid = 1'b0; ovf_clr = 1'b0;
        check("ovf_set_wins", 32'(overflow), 32'd1);
        ovf_clr = 1'b1; tick(); ovf_clr = 1'b0;
        check("ovf_cleared2", 32'(overflow), 32'd0);
        tx_hold = 1'b0;
        wait_drain("drain_full", 2000);
        check("full_pulses", 32'(out_log.size() - n0), 32'd16);
        for (int i = 0; i < 16 && n0 + i < out_log.size(); i++)
            check("full_data", 32'(out_log[n0 + i]), 32'(i));

        // 40 bytes through two pointer wraps with quick draining
        busy_delay = 1; busy_len = 2;
        n0 = out_log.size();
        for (int i = 0; i < 40; i++) push_hs(8'(i));
        wait_drain("drain_wrap", 3000);
        check("wrap_pulses", 32'(out_log.size() - n0), 32'd40);
        for (int i = 0; i < 40 && n0 + i < out_log.size(); i++)
            check("wrap_data", 32'(out_log[n0 + i]), 32'(i));

        // Transmitter never asserts busy: timeout path
        tx_never = 1'b1;
        n0 = out_log.size();
        push_byte(8'h5A);
        push_byte(8'hA5);
        wait_drain("drain_timeout", 200);
        check("timeout_pulses", 32'(out_log.size() - n0), 32'd2);
        if (out_log.size() >= n0 + 2) begin
            check("timeout_gap", 32'(out_cyc[n0 + 1] - out_cyc[n0]), 32'd6);
            check("timeout_data", 32'(out_log[n0 + 1]), 32'hA5);
        end
        tx_never = 1'b0;

        // Reset while waiting for busy to fall with five bytes queued
        busy_delay = 2; busy_len = 20;
        for (int i = 0; i < 6; i++) begin
            in_valid = 1'b1; in_data = 8'hA0 + 8'(i);
            tick();
        end
        in_valid = 1'b0;
        for (int k = 0; k < 100 && !m_saw_busy; k++) tick();
        check("reached_wait_lo", 32'(m_saw_busy), 32'd1);
        check("queued_before_rst", 32'(count), 32'd5);
        rst_n = 1'b0;
        #1;
        check("rst_mid_count", 32'(count), 32'd0);
        check("rst_mid_out_valid", 32'(out_valid), 32'd0);
        check("rst_mid_in_ready", 32'(in_ready), 32'd1);
        tick();
        rst_n = 1'b1;
        n0 = out_log.size();
        repeat (10) tick();
        check("post_rst_pulses", 32'(out_log.size() - n0), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
